// File: rtl/fib_pkg.sv
// Shared constants and state encoding for the Fibonacci generator/decoder pair.
package fib_pkg;

  localparam int FIB_W       = 16;
  localparam int SUM_W       = 17;
  localparam int IDX_W       = 5;
  localparam int FIB_MAX_IDX = 24;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OP   = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/fib_index_if.sv
// start/ready/done_tick handshake plus operand and result for the inverse Fibonacci decoder.
interface fib_index_if;
  import fib_pkg::*;

  logic             start;
  logic [FIB_W-1:0] f;
  logic             ready;
  logic             done_tick;
  logic [IDX_W-1:0] i;
  logic             exact;

  modport master (output start, f, input ready, done_tick, i, exact);
  modport slave  (input start, f, output ready, done_tick, i, exact);

endinterface

// File: rtl/fib_index.sv
// Inverse Fibonacci FSMD: largest i with F(i) <= f, plus exact-match flag; N+1 cycle latency.
// FIB_INDEX_NEAREST_EN rounds i to the nearest Fibonacci index (ties low); exact keeps floor meaning.
module fib_index
  import fib_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fib_index_if.slave  bus
);

  state_t             r_state, w_state_nxt;
  logic [FIB_W-1:0]   r_f, w_f_nxt;
  logic [SUM_W-1:0]   r_t0, w_t0_nxt;
  logic [SUM_W-1:0]   r_t1, w_t1_nxt;
  logic [IDX_W-1:0]   r_n, w_n_nxt;
  logic [IDX_W-1:0]   r_i, w_i_nxt;
  logic               r_exact, w_exact_nxt;

  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   w_f_ext;
  logic [IDX_W-1:0]   w_term_idx;

  // F(25) = 75025 fits in 17 bits, so the running sum never wraps.
  assign w_sum   = r_t0 + r_t1;
  assign w_f_ext = {1'b0, r_f};

`ifdef FIB_INDEX_NEAREST_EN
  logic [SUM_W-1:0]   w_gap_hi;
  logic [SUM_W-1:0]   w_gap_lo;

  assign w_gap_hi   = w_sum - w_f_ext;
  assign w_gap_lo   = w_f_ext - r_t1;
  assign w_term_idx = (w_gap_hi < w_gap_lo) ? r_n + 5'd1 : r_n;
`else
  assign w_term_idx = r_n;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_f     <= '0;
      r_t0    <= '0;
      r_t1    <= '0;
      r_n     <= '0;
      r_i     <= '0;
      r_exact <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_f     <= w_f_nxt;
      r_t0    <= w_t0_nxt;
      r_t1    <= w_t1_nxt;
      r_n     <= w_n_nxt;
      r_i     <= w_i_nxt;
      r_exact <= w_exact_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_f_nxt     = r_f;
    w_t0_nxt    = r_t0;
    w_t1_nxt    = r_t1;
    w_n_nxt     = r_n;
    w_i_nxt     = r_i;
    w_exact_nxt = r_exact;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_f_nxt     = bus.f;
          w_t0_nxt    = '0;
          w_t1_nxt    = 17'd1;
          w_n_nxt     = 5'd1;
          w_state_nxt = OP;
        end
      end
      OP: begin
        if (r_f == '0) begin
          w_i_nxt     = '0;
          w_exact_nxt = 1'b1;
          w_state_nxt = DONE;
        end else if (w_sum > w_f_ext) begin
          w_i_nxt     = w_term_idx;
          w_exact_nxt = (r_t1 == w_f_ext);
          w_state_nxt = DONE;
        end else begin
          w_t1_nxt = w_sum;
          w_t0_nxt = r_t1;
          w_n_nxt  = r_n + 5'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ready     = (r_state == IDLE);
  assign bus.done_tick = (r_state == DONE);
  assign bus.i         = r_i;
  assign bus.exact     = r_exact;

endmodule

// File: tb/tb_fib_index.sv
// Randomized scoreboard bench for fib_index against a table-driven Fibonacci reference.
module tb_fib_index;
  import fib_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fib_index_if bus();

  fib_index dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int ei;
    bit ex;
    int lat;
    int stamp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: build the Fibonacci table and pick the largest index whose value fits.
  function automatic void ref_model(input int fv, output int ei, output bit ex, output int lat);
    int fib[27];
    int fl;
    fib[0] = 0;
    fib[1] = 1;
    for (int k = 2; k < 27; k++) fib[k] = fib[k-1] + fib[k-2];
    fl = 0;
    for (int k = 1; k < 26; k++) if (fib[k] <= fv) fl = k;
    ex = (fib[fl] == fv);
    ei = fl;
`ifdef FIB_INDEX_NEAREST_EN
    if (fv != 0 && (fib[fl+1] - fv) < (fv - fib[fl])) ei = fl + 1;
`endif
    lat = ((fl > 1) ? fl : 1) + 1;
  endfunction

  // Issue one search on the first ready cycle; noise on start/f while busy must be ignored.
  task automatic issue(input int fv);
    int   n;
    int   ei;
    bit   ex;
    int   lat;
    exp_t e;
    n = 0;
    while (!bus.ready && n < 200) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.f     = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ready) begin
      check("ready_timeout", bus.ready, 1);
    end else begin
      ref_model(fv, ei, ex, lat);
      e.ei    = ei;
      e.ex    = ex;
      e.lat   = lat;
      e.stamp = cyc;
      sb.push_back(e);
      bus.start = 1'b1;
      bus.f     = fv[15:0];
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.f     = 16'($urandom);
    end
  endtask

  // Monitor: pops the scoreboard on every done_tick and checks held results while idle.
  initial begin
    int   last_i;
    bit   last_x;
    bit   prev_done;
    exp_t e;
    last_i    = 0;
    last_x    = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_i    = 0;
        last_x    = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (prev_done) check("ready_after_done", bus.ready, 1);
        if (bus.done_tick) begin
          done_seen++;
          if (sb.size() == 0) begin
            check("unexpected_done_queue_size", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("i", bus.i, e.ei);
            check("exact", bus.exact, e.ex);
            check("latency", cyc - e.stamp, e.lat);
            last_i = e.ei;
            last_x = e.ex;
          end
        end else if (bus.ready) begin
          check("held_i", bus.i, last_i);
          check("held_exact", bus.exact, last_x);
        end
        prev_done = bus.done_tick;
      end
    end
  end

  initial begin
    int dir_vals[$] = '{0, 1, 100, 7, 4, 65535, 46368, 2, 3, 5, 144, 46367};
    int n;
    int base;
    int fv;
    bus.start = 1'b0;
    bus.f     = '0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done_tick, 0);
    check("rst_i", bus.i, 0);
    check("rst_exact", bus.exact, 0);

    // Abort a long search with a two-cycle reset.
    issue(46368);
    repeat (8) begin @(posedge clk); #1; end
    check("busy_before_abort", bus.ready, 0);
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_ready", bus.ready, 1);
    check("abort_done", bus.done_tick, 0);
    check("abort_i", bus.i, 0);
    check("abort_exact", bus.exact, 0);
    reset = 1'b1;
    sb.delete();
    base = done_seen;
    repeat (40) begin @(posedge clk); #1; end
    check("no_done_after_abort", done_seen - base, 0);

    foreach (dir_vals[k]) issue(dir_vals[k]);

    repeat (60) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
      end
      if ($urandom_range(0, 1) == 1) fv = int'($urandom_range(0, 200));
      else fv = int'($urandom_range(0, 65535));
      issue(fv);
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
